// File: rtl/dh_pkg.sv
// Shared Diffie-Hellman datapath definitions: FSM encoding for the divider
// sequencer and the default operand width used by the exponentiation engines.
package dh_pkg;

    localparam int DH_W = 16;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_BUSY  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        ISSUE = ST_ISSUE,
        BUSY  = ST_BUSY,
        RESP  = ST_RESP
    } state_t;

endpackage

// File: rtl/div_share_arbiter_rr_pick.sv
// Combinational round-robin picker: one-hot grant and its index, searching
// from i_last+1 upwards (mod N); all-zero grant when nothing is requested.
module rr_pick #(
    parameter int N  = 2,
    parameter int IW = 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_last,
    output logic [N-1:0]  o_grant,
    output logic [IW-1:0] o_idx
);

    // Walk from lowest to highest priority so the nearest requester overwrites.
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        for (int k = N; k >= 1; k--) begin
            if (i_req[(int'(i_last) + k) % N]) begin
                o_grant                            = '0;
                o_grant[(int'(i_last) + k) % N]    = 1'b1;
                o_idx                              = IW'((int'(i_last) + k) % N);
            end
        end
    end

endmodule

// File: rtl/div_share_arbiter.sv
// Shares one divider between N_REQ requesters with round-robin arbitration,
// divide-by-zero bypass and a hung-divider timeout; one op in flight at a time.
module div_share_arbiter
    import dh_pkg::*;
#(
    parameter int N_REQ   = 2,
    parameter int W       = DH_W,
    parameter int TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [N_REQ*W-1:0]   req_dividend,
    input  logic [N_REQ*W-1:0]   req_divisor,
    output logic [N_REQ-1:0]     req_ready,
    output logic [N_REQ-1:0]     rsp_valid,
    output logic [W-1:0]         rsp_quotient,
    output logic [W-1:0]         rsp_remainder,
    output logic                 rsp_err,
    output logic [W-1:0]         div_dividend,
    output logic [W-1:0]         div_divider,
    output logic                 div_start,
    input  logic [W-1:0]         div_quotient,
    input  logic [W-1:0]         div_remainder,
    input  logic                 div_ready
);

    localparam int OW  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int TCW = $clog2(TIMEOUT);

    state_t           r_state;
    state_t           w_next;
    logic [OW-1:0]    r_owner;
    logic [OW-1:0]    r_last_grant;
    logic [OW-1:0]    w_grant_idx;
    logic [N_REQ-1:0] w_grant;
    logic [TCW-1:0]   r_tcnt;
    logic [W-1:0]     r_rsp_q;
    logic [W-1:0]     r_rsp_r;
    logic             r_rsp_err;
    logic [W-1:0]     r_div_a;
    logic [W-1:0]     r_div_b;
    logic [W-1:0]     w_sel_a;
    logic [W-1:0]     w_sel_b;
    logic             w_hs;
    logic             w_tmo;

    rr_pick #(
        .N  (N_REQ),
        .IW (OW)
    ) u_rr_pick (
        .i_req   (req_valid),
        .i_last  (r_last_grant),
        .o_grant (w_grant),
        .o_idx   (w_grant_idx)
    );

    assign req_ready     = (r_state == IDLE) ? w_grant : '0;
    assign w_hs          = |(req_valid & req_ready);
    assign w_sel_a       = req_dividend[w_grant_idx*W +: W];
    assign w_sel_b       = req_divisor[w_grant_idx*W +: W];
    assign w_tmo         = (r_tcnt == TCW'(TIMEOUT - 1));

    assign div_start     = (r_state == ISSUE);
    assign div_dividend  = r_div_a;
    assign div_divider   = r_div_b;
    assign rsp_quotient  = r_rsp_q;
    assign rsp_remainder = r_rsp_r;
    assign rsp_err       = r_rsp_err;

    always_comb begin
        rsp_valid = '0;
        if (r_state == RESP) begin
            rsp_valid[r_owner] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_hs) w_next = (w_sel_b == '0) ? RESP : ISSUE;
            ISSUE:   w_next = BUSY;
            BUSY:    if (div_ready || w_tmo) w_next = RESP;
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_owner      <= '0;
            r_last_grant <= OW'(N_REQ - 1);
            r_tcnt       <= '0;
            r_rsp_q      <= '0;
            r_rsp_r      <= '0;
            r_rsp_err    <= 1'b0;
            r_div_a      <= '0;
            r_div_b      <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_hs) begin
                        r_div_a      <= w_sel_a;
                        r_div_b      <= w_sel_b;
                        r_owner      <= w_grant_idx;
                        r_last_grant <= w_grant_idx;
                        // Zero divisor never reaches the divider; answer directly.
                        if (w_sel_b == '0) begin
                            r_rsp_q   <= '1;
                            r_rsp_r   <= w_sel_a;
                            r_rsp_err <= 1'b1;
                        end
                    end
                end
                ISSUE: r_tcnt <= '0;
                BUSY: begin
                    if (div_ready) begin
                        r_rsp_q   <= div_quotient;
                        r_rsp_r   <= div_remainder;
                        r_rsp_err <= 1'b0;
                    end else if (w_tmo) begin
                        r_rsp_q   <= '0;
                        r_rsp_r   <= '0;
                        r_rsp_err <= 1'b1;
                    end else begin
                        r_tcnt <= r_tcnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_share_arbiter.sv
// Bench for div_share_arbiter: table vectors, corner sequences and random ops
// checked every cycle against a transaction-level model of the arbiter.
module tb_div_share_arbiter;

    localparam int N  = 2;
    localparam int W  = 16;
    localparam int TO = 64;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [N-1:0]   req_valid = '0;
    logic [N*W-1:0] req_dividend = '0;
    logic [N*W-1:0] req_divisor = '0;
    logic [N-1:0]   req_ready;
    logic [N-1:0]   rsp_valid;
    logic [W-1:0]   rsp_quotient, rsp_remainder;
    logic           rsp_err;
    logic [W-1:0]   div_dividend, div_divider;
    logic           div_start;
    logic [W-1:0]   div_quotient, div_remainder;
    logic           div_ready;

    div_share_arbiter #(.N_REQ(N), .W(W), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_dividend(req_dividend), .req_divisor(req_divisor),
        .req_ready(req_ready), .rsp_valid(rsp_valid),
        .rsp_quotient(rsp_quotient), .rsp_remainder(rsp_remainder), .rsp_err(rsp_err),
        .div_dividend(div_dividend), .div_divider(div_divider), .div_start(div_start),
        .div_quotient(div_quotient), .div_remainder(div_remainder), .div_ready(div_ready)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Divider model: ready in the d_cfg-th cycle after the start pulse ends.
    int         d_cfg = 0;
    bit         hung = 1'b0;
    int         m_cnt;
    bit         m_act;
    logic [W-1:0] m_q, m_r;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_act <= 1'b0;
            m_cnt <= 0;
            m_q   <= '0;
            m_r   <= '0;
        end else if (div_start) begin
            m_act <= 1'b1;
            m_cnt <= 0;
            m_q   <= div_dividend / div_divider;
            m_r   <= div_dividend % div_divider;
        end else if (m_act) begin
            m_cnt <= m_cnt + 1;
        end
    end
    assign div_ready     = m_act && !hung && (m_cnt == d_cfg);
    assign div_quotient  = m_q;
    assign div_remainder = m_r;

    // Transaction-level reference: who wins, when the answer is due, what it is.
    bit           m_busy = 1'b0;
    int           m_last = N - 1;
    int           m_owner, m_hs, m_rsp_at, idx, win;
    bit           e_start, e_err;
    logic [W-1:0] e_a, e_b, e_q, e_r;
    logic [N-1:0] exp_rdy, exp_rsp;
    int           rsp1_cnt = 0;
    int           rsp_any_cnt = 0;

    always @(negedge clk) begin
        if (!rst) begin
            m_busy = 1'b0;
            m_last = N - 1;
        end else begin
            exp_rdy = '0;
            win = -1;
            if (!m_busy) begin
                for (int k = 1; k <= N; k++) begin
                    idx = (m_last + k) % N;
                    if (win < 0 && req_valid[idx]) win = idx;
                end
                if (win >= 0) exp_rdy[win] = 1'b1;
            end
            chk("req_ready", 64'(req_ready), 64'(exp_rdy));

            exp_rsp = '0;
            if (m_busy && cyc == m_rsp_at) exp_rsp[m_owner] = 1'b1;
            chk("rsp_valid", 64'(rsp_valid), 64'(exp_rsp));
            if (exp_rsp != '0) begin
                chk("rsp_quotient", 64'(rsp_quotient), 64'(e_q));
                chk("rsp_remainder", 64'(rsp_remainder), 64'(e_r));
                chk("rsp_err", 64'(rsp_err), 64'(e_err));
            end

            chk("div_start", 64'(div_start), 64'(m_busy && e_start && cyc == m_hs + 1));
            if (m_busy && e_start && cyc == m_hs + 1) begin
                chk("div_dividend", 64'(div_dividend), 64'(e_a));
                chk("div_divider", 64'(div_divider), 64'(e_b));
            end

            if (rsp_valid[1]) rsp1_cnt++;
            if (rsp_valid != '0) rsp_any_cnt++;

            if (m_busy && cyc == m_rsp_at) begin
                m_busy = 1'b0;
            end else if (win >= 0) begin
                m_busy  = 1'b1;
                m_owner = win;
                m_last  = win;
                m_hs    = cyc;
                e_a     = req_dividend[win*W +: W];
                e_b     = req_divisor[win*W +: W];
                if (e_b == '0) begin
                    e_start = 1'b0; m_rsp_at = cyc + 1;
                    e_q = '1; e_r = e_a; e_err = 1'b1;
                end else if (hung) begin
                    e_start = 1'b1; m_rsp_at = cyc + TO + 2;
                    e_q = '0; e_r = '0; e_err = 1'b1;
                end else begin
                    e_start = 1'b1; m_rsp_at = cyc + 3 + d_cfg;
                    e_q = e_a / e_b; e_r = e_a % e_b; e_err = 1'b0;
                end
            end
        end
    end

    task automatic do_req(input int who, input logic [W-1:0] a, input logic [W-1:0] b,
                          output int hs);
        hs = -1;
        req_dividend[who*W +: W] = a;
        req_divisor[who*W +: W]  = b;
        req_valid[who] = 1'b1;
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            if (req_ready[who]) begin
                hs = cyc;
                break;
            end
        end
        if (hs < 0) begin
            n_chk++; n_fail++;
            $display("FAIL grant_wait req%0d: no grant, expected one", who);
        end
        @(posedge clk); #1;
        req_valid[who] = 1'b0;
    endtask

    task automatic wait_rsp(input int who, output int rc, output logic [W-1:0] q,
                            output logic [W-1:0] r, output logic e);
        rc = -1; q = '0; r = '0; e = 1'b0;
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            if (rsp_valid[who]) begin
                rc = cyc; q = rsp_quotient; r = rsp_remainder; e = rsp_err;
                break;
            end
        end
        if (rc < 0) begin
            n_chk++; n_fail++;
            $display("FAIL rsp_wait req%0d: no response, expected one", who);
        end
    endtask

    typedef struct {
        int           who;
        logic [W-1:0] a, b;
        int           d;
        bit           hng;
        logic [W-1:0] q, r;
        bit           err;
        int           lat;
    } vec_t;

    vec_t tbl[6];

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int hs, rc, c1, first, got;
        logic [W-1:0] q, r, a, b;
        logic e;
        logic [N-1:0] mask;

        tbl[0] = '{0, 16'd1000,  16'd7,   5, 1'b0, 16'd142,   16'd6,  1'b0, 8};
        tbl[1] = '{1, 16'd55,    16'd0,   0, 1'b0, 16'hFFFF,  16'd55, 1'b1, 1};
        tbl[2] = '{0, 16'd1234,  16'd5,   0, 1'b1, 16'd0,     16'd0,  1'b1, 66};
        tbl[3] = '{1, 16'd65535, 16'd1,   0, 1'b0, 16'd65535, 16'd0,  1'b0, 3};
        tbl[4] = '{0, 16'd17,    16'd100, 2, 1'b0, 16'd0,     16'd17, 1'b0, 5};
        tbl[5] = '{1, 16'd0,     16'd3,   1, 1'b0, 16'd0,     16'd0,  1'b0, 4};

        repeat (3) @(posedge clk);
        #1;
        chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("reset_rsp_q", 64'(rsp_quotient), 64'd0);
        chk("reset_rsp_r", 64'(rsp_remainder), 64'd0);
        chk("reset_rsp_err", 64'(rsp_err), 64'd0);
        chk("reset_div_start", 64'(div_start), 64'd0);
        chk("reset_div_a", 64'(div_dividend), 64'd0);
        chk("reset_div_b", 64'(div_divider), 64'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        for (int v = 0; v < 6; v++) begin
            d_cfg = tbl[v].d;
            hung  = tbl[v].hng;
            do_req(tbl[v].who, tbl[v].a, tbl[v].b, hs);
            wait_rsp(tbl[v].who, rc, q, r, e);
            chk("tbl_latency", 64'(rc - hs), 64'(tbl[v].lat));
            chk("tbl_quotient", 64'(q), 64'(tbl[v].q));
            chk("tbl_remainder", 64'(r), 64'(tbl[v].r));
            chk("tbl_err", 64'(e), 64'(tbl[v].err));
            @(posedge clk); #1;
        end
        hung = 1'b0;

        // Contention: both held valid, grants must alternate starting at 0.
        d_cfg = 1;
        req_dividend = {16'd200, 16'd100};
        req_divisor  = {16'd7, 16'd9};
        req_valid    = 2'b11;
        for (int n = 0; n < 4; n++) begin
            got = -1;
            for (int t = 0; t < 100 && got < 0; t++) begin
                @(negedge clk);
                if (rsp_valid == 2'b01) got = 0;
                else if (rsp_valid == 2'b10) got = 1;
            end
            chk("contention_order", 64'(got), 64'(n % 2));
            chk("contention_q", 64'(rsp_quotient), (n % 2 == 0) ? 64'd11 : 64'd28);
            chk("contention_r", 64'(rsp_remainder), (n % 2 == 0) ? 64'd1 : 64'd4);
        end
        @(posedge clk); #1;
        req_valid = '0;
        @(posedge clk); #1;

        // Withdrawn request while BUSY must never be served.
        d_cfg = 6;
        do_req(0, 16'd300, 16'd7, hs);
        @(posedge clk); #1;
        req_dividend[W +: W] = 16'd9;
        req_divisor[W +: W]  = 16'd3;
        req_valid[1] = 1'b1;
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        c1 = rsp1_cnt;
        wait_rsp(0, rc, q, r, e);
        chk("withdraw_q", 64'(q), 64'd42);
        chk("withdraw_r", 64'(r), 64'd6);
        @(posedge clk); #1;
        do_req(0, 16'd40, 16'd6, hs);
        wait_rsp(0, rc, q, r, e);
        chk("after_withdraw_q", 64'(q), 64'd6);
        chk("after_withdraw_r", 64'(r), 64'd4);
        chk("withdraw_no_rsp1", 64'(rsp1_cnt), 64'(c1));
        @(posedge clk); #1;

        // Reset while BUSY abandons the op silently.
        d_cfg = 10;
        do_req(0, 16'd500, 16'd3, hs);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("midreset_div_start", 64'(div_start), 64'd0);
        chk("midreset_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("midreset_rsp_q", 64'(rsp_quotient), 64'd0);
        chk("midreset_rsp_r", 64'(rsp_remainder), 64'd0);
        chk("midreset_rsp_err", 64'(rsp_err), 64'd0);
        chk("midreset_div_a", 64'(div_dividend), 64'd0);
        chk("midreset_div_b", 64'(div_divider), 64'd0);
        chk("midreset_req_ready", 64'(req_ready), 64'd0);
        c1 = rsp_any_cnt;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (15) @(posedge clk);
        #1;
        chk("midreset_no_rsp", 64'(rsp_any_cnt), 64'(c1));
        d_cfg = 0;
        req_dividend = {16'd77, 16'd81};
        req_divisor  = {16'd7, 16'd9};
        req_valid    = 2'b11;
        first = 0;
        for (int t = 0; t < 100 && first == 0; t++) begin
            @(negedge clk);
            first = int'(req_ready);
        end
        chk("first_grant_after_reset", 64'(first), 64'd1);
        @(posedge clk); #1;
        req_valid = '0;
        wait_rsp(0, rc, q, r, e);
        chk("after_reset_q", 64'(q), 64'd9);
        chk("after_reset_r", 64'(r), 64'd0);
        @(posedge clk); #1;

        // Random traffic, checked cycle by cycle by the reference model.
        for (int it = 0; it < 40; it++) begin
            hung  = ($urandom_range(0, 15) == 0);
            d_cfg = int'($urandom_range(0, 6));
            mask  = N'($urandom_range(1, (1 << N) - 1));
            for (int i = 0; i < N; i++) begin
                a = W'($urandom);
                case ($urandom_range(0, 7))
                    0:       b = '0;
                    1:       b = W'($urandom_range(1, 15));
                    default: b = W'($urandom_range(1, 65535));
                endcase
                req_dividend[i*W +: W] = a;
                req_divisor[i*W +: W]  = b;
            end
            req_valid = mask;
            got = 0;
            for (int t = 0; t < 100 && got == 0; t++) begin
                @(negedge clk);
                if (req_ready != '0) got = 1;
            end
            if (got == 0) begin
                n_chk++; n_fail++;
                $display("FAIL rand_grant: no grant, expected one");
            end
            @(posedge clk); #1;
            req_valid = '0;
            got = 0;
            for (int t = 0; t < 200 && got == 0; t++) begin
                @(negedge clk);
                if (rsp_valid != '0) got = 1;
            end
            if (got == 0) begin
                n_chk++; n_fail++;
                $display("FAIL rand_rsp: no response, expected one");
            end
            @(posedge clk); #1;
        end
        hung = 1'b0;
        repeat (3) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
